// File: rtl/level_sync_filter_pkg.sv
// Shared types and constants for the level synchronizer/filter and its synchronizer stage.
package level_sync_filter_pkg;

  localparam int MIN_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    CONF_HIGH = 2'd1,
    HIGH      = 2'd2,
    CONF_LOW  = 2'd3
  } filter_state_e;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop single-bit synchronizer with asynchronous active-low clear; reusable for pointer bits.
module bit_synchronizer
  import level_sync_filter_pkg::*;
#(
  parameter int p_sync_stages = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  if (p_sync_stages < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("bit_synchronizer: p_sync_stages must be >= %0d", MIN_SYNC_STAGES);
  end

  logic [p_sync_stages-1:0] stages;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stages <= '0;
    end else begin
      stages <= {stages[p_sync_stages-2:0], d};
    end
  end

  assign q = stages[p_sync_stages-1];

endmodule

// File: rtl/level_sync_filter.sv
// Synchronizes an async level and only passes transitions stable for p_filter_cycles samples.
// Optional rejected-transition counter: define LEVEL_SYNC_FILTER_GLITCH_COUNT_EN.
module level_sync_filter
  import level_sync_filter_pkg::*;
#(
  parameter int p_sync_stages   = 2,
  parameter int p_filter_cycles = 4,
  parameter int p_glitch_width  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic async_val,
  output logic level_out,
  output logic busy
`ifdef LEVEL_SYNC_FILTER_GLITCH_COUNT_EN
  ,
  output logic [p_glitch_width-1:0] glitch_cnt
`endif
);

  if (p_filter_cycles < 1) begin : g_bad_filter
    $error("level_sync_filter: p_filter_cycles must be >= 1");
  end

  localparam int CNT_W = $clog2(p_filter_cycles + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam cnt_t CNT_LAST = cnt_t'(p_filter_cycles - 1);

  logic          sync_s;
  filter_state_e state, state_next;
  cnt_t          cnt, cnt_next;
  logic          abort;

  bit_synchronizer #(
    .p_sync_stages(p_sync_stages)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (async_val),
    .q    (sync_s)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    abort      = 1'b0;
    case (state)
      LOW: begin
        if (sync_s) begin
          if (p_filter_cycles == 1) begin
            state_next = HIGH;
          end else begin
            state_next = CONF_HIGH;
            cnt_next   = CNT_ONE;
          end
        end
      end
      CONF_HIGH: begin
        if (!sync_s) begin
          state_next = LOW;
          cnt_next   = '0;
          abort      = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_next = HIGH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (!sync_s) begin
          if (p_filter_cycles == 1) begin
            state_next = LOW;
          end else begin
            state_next = CONF_LOW;
            cnt_next   = CNT_ONE;
          end
        end
      end
      CONF_LOW: begin
        if (sync_s) begin
          state_next = HIGH;
          cnt_next   = '0;
          abort      = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_next = LOW;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = LOW;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= LOW;
      cnt       <= '0;
      level_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      level_out <= (state_next == HIGH) || (state_next == CONF_LOW);
      busy      <= (state_next == CONF_HIGH) || (state_next == CONF_LOW);
    end
  end

`ifdef LEVEL_SYNC_FILTER_GLITCH_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      glitch_cnt <= '0;
    end else if (abort && (glitch_cnt != '1)) begin
      glitch_cnt <= glitch_cnt + p_glitch_width'(1);
    end
  end
`endif

endmodule
